fastcmd_encoder: RTL and testbench

Transmit end of the fast-command link. The block accepts 8-bit command requests from the control logic into a small FIFO. It serialises one 8-bit frame per bunch crossing (BX), MSB first, at one bit per clk. Empty slots are filled with the IDLE code, and a BCR is inserted automatically once per orbit. Its serial output drives the line that the front-end fast-command decoder samples.

---
 rtl/fastcmd_encoder.sv | 101 ++++++++++
 tb/tb_fastcmd_encoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fastcmd_encoder.sv
// rtl/fastcmd_encoder.sv - fast-command link transmitter: command FIFO, frame select, MSB-first serialiser
// One 8-bit frame per BX; the next frame is chosen and loaded at phase 7.
module fastcmd_encoder #(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] IDLE_CODE = 8'hAC,
  parameter logic [7:0] BCR_CODE  = 8'h2D,
  parameter int         ORBIT_LEN = 3564,
  parameter int         BCR_BX    = 3563
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               cmd_data,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     bcr_en,
  output logic                     sdo,
  output logic                     frame_start,
  output logic [11:0]              bx_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     cmd_sent,
  output logic                     bcr_sent,
  output logic                     overflow
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [11:0] BX_LAST  = 12'(ORBIT_LEN - 1);
  localparam logic [11:0] BX_BCR   = 12'(BCR_BX);
  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  logic [2:0]    phase;
  logic [7:0]    shreg;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [11:0]   bx_next;
  logic          frame_end;
  logic          sel_bcr;
  logic          push;
  logic          pop;

  // Pop decision uses the level before this cycle's push, so a command
  // arriving into an empty FIFO at phase 7 waits for the following frame.
  always_comb begin
    frame_end = (phase == 3'd7);
    bx_next   = (bx_cnt == BX_LAST) ? 12'd0 : bx_cnt + 12'd1;
    sel_bcr   = frame_end && bcr_en && (bx_next == BX_BCR);
    pop       = frame_end && !sel_bcr && (fifo_level != '0);
    push      = cmd_valid && cmd_ready;
  end

  assign cmd_ready   = (fifo_level != LVL_FULL);
  assign sdo         = shreg[7];
  assign frame_start = (phase == 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= 3'd0;
      bx_cnt     <= 12'd0;
      shreg      <= IDLE_CODE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      cmd_sent   <= 1'b0;
      bcr_sent   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      phase    <= phase + 3'd1;
      cmd_sent <= pop;
      bcr_sent <= sel_bcr;
      if (frame_end) begin
        bx_cnt <= bx_next;
        if (sel_bcr)
          shreg <= BCR_CODE;
        else if (pop)
          shreg <= mem[rd_ptr];
        else
          shreg <= IDLE_CODE;
      end else begin
        shreg <= {shreg[6:0], 1'b0};
      end
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (cmd_valid && !cmd_ready)
        overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= cmd_data;
  end

endmodule

// File: tb/tb_fastcmd_encoder.sv
// tb/tb_fastcmd_encoder.sv - directed bench for fastcmd_encoder
// Default-parameter instance plus a short-orbit instance for the BCR slot.
module tb_fastcmd_encoder;

  localparam logic [7:0] IDLE = 8'hAC;
  localparam logic [7:0] BCR  = 8'h2D;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        bcr_en = 1'b0;
  logic        cmd_ready, sdo, frame_start, cmd_sent, bcr_sent, overflow;
  logic [11:0] bx_cnt;
  logic [2:0]  fifo_level;

  logic [7:0]  s_cmd_data = 8'h00;
  logic        s_cmd_valid = 1'b0;
  logic        s_bcr_en = 1'b0;
  logic        s_cmd_ready, s_sdo, s_frame_start, s_cmd_sent, s_bcr_sent, s_overflow;
  logic [11:0] s_bx_cnt;
  logic [2:0]  s_fifo_level;

  logic        sel_s = 1'b0;
  logic        sdo_mux;
  assign sdo_mux = sel_s ? s_sdo : sdo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fastcmd_encoder dut (
    .clk(clk), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .bcr_en(bcr_en), .sdo(sdo), .frame_start(frame_start),
    .bx_cnt(bx_cnt), .fifo_level(fifo_level), .cmd_sent(cmd_sent),
    .bcr_sent(bcr_sent), .overflow(overflow)
  );

  fastcmd_encoder #(.ORBIT_LEN(8), .BCR_BX(7)) dut_s (
    .clk(clk), .reset(reset), .cmd_data(s_cmd_data), .cmd_valid(s_cmd_valid),
    .cmd_ready(s_cmd_ready), .bcr_en(s_bcr_en), .sdo(s_sdo), .frame_start(s_frame_start),
    .bx_cnt(s_bx_cnt), .fifo_level(s_fifo_level), .cmd_sent(s_cmd_sent),
    .bcr_sent(s_bcr_sent), .overflow(s_overflow)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        sdo;
    logic        fs;
    logic [11:0] bx;
    logic [2:0]  level;
    logic        ready;
    logic        sent;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] codes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void add(input logic rst, input logic valid, input logic [7:0] data,
                              input logic [7:0] fb, input int ph, input int bx,
                              input int lvl, input logic sent, input logic ovf);
    vec_t v;
    logic [7:0] b;
    b       = fb;
    v.rst   = rst;
    v.valid = valid;
    v.data  = data;
    v.sdo   = b[7 - ph];
    v.fs    = (ph == 0);
    v.bx    = 12'(bx);
    v.level = 3'(lvl);
    v.ready = (lvl != 4);
    v.sent  = sent;
    v.ovf   = ovf;
    vecs.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    s_cmd_valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Samples the frame starting at the current phase-0 sample; ends on the next phase 0.
  task automatic grab_chk(string name, logic [7:0] exp);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b[7 - i] = sdo_mux;
      step();
    end
    chk(name, b, exp);
  endtask

  function automatic int lvl3(int k);
    if (k <= 2)  return k + 1;
    if (k < 7)   return 4;
    if (k < 15)  return 3;
    if (k < 23)  return 2;
    if (k < 31)  return 1;
    return 0;
  endfunction

  initial begin
    // Idle frames after reset
    add(1, 0, 8'h00, IDLE, 0, 0, 0, 0, 0);
    for (int k = 0; k < 15; k++)
      add(0, 0, 8'h00, IDLE, (k + 1) % 8, (k + 1) / 8, 0, 0, 0);
    // Single command pushed at phase 3 of BX 0
    add(1, 0, 8'h00, IDLE, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++)
      add(0, k == 3, 8'h4B, ((k + 1) / 8 == 1) ? 8'h4B : IDLE, (k + 1) % 8, (k + 1) / 8,
          (k >= 3 && k < 7) ? 1 : 0, k == 7, 0);
    // Five back-to-back pushes into a depth-4 FIFO
    add(1, 0, 8'h00, IDLE, 0, 0, 0, 0, 0);
    for (int k = 0; k < 48; k++) begin
      int b;
      b = (k + 1) / 8;
      add(0, k <= 4, (k <= 4) ? codes[k] : 8'h00, (b >= 1 && b <= 4) ? codes[b - 1] : IDLE,
          (k + 1) % 8, b, lvl3(k), (k == 7 || k == 15 || k == 23 || k == 31), k >= 4);
    end

    foreach (vecs[i]) begin
      reset     = vecs[i].rst;
      cmd_valid = vecs[i].valid;
      cmd_data  = vecs[i].data;
      step();
      chk($sformatf("v%0d_sdo", i), sdo, vecs[i].sdo);
      chk($sformatf("v%0d_fs", i), frame_start, vecs[i].fs);
      chk($sformatf("v%0d_bx", i), bx_cnt, vecs[i].bx);
      chk($sformatf("v%0d_level", i), fifo_level, vecs[i].level);
      chk($sformatf("v%0d_ready", i), cmd_ready, vecs[i].ready);
      chk($sformatf("v%0d_sent", i), cmd_sent, vecs[i].sent);
      chk($sformatf("v%0d_bcrsent", i), bcr_sent, 1'b0);
      chk($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
    end
    reset = 1'b0;
    cmd_valid = 1'b0;

    // Reset mid-frame at BX 7 phase 4 with two entries queued
    cmd_valid = 1'b1; cmd_data = 8'h4B; step();
    cmd_data = 8'h5A; step();
    cmd_data = 8'h66; step();
    cmd_valid = 1'b0;
    repeat (5) step();
    chk("rst_pre_sent", cmd_sent, 1'b1);
    chk("rst_pre_bx", bx_cnt, 12'd7);
    chk("rst_pre_level", fifo_level, 3'd2);
    repeat (4) step();
    chk("rst_pre_ovf", overflow, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_sdo", sdo, 1'b1);
    chk("rst_level", fifo_level, 3'd0);
    chk("rst_bx", bx_cnt, 12'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_fs", frame_start, 1'b1);
    chk("rst_ready", cmd_ready, 1'b1);
    grab_chk("rst_frame0", IDLE);
    grab_chk("rst_frame1", IDLE);
    chk("rst_sent", cmd_sent, 1'b0);

    // Push and pop in the same phase-7 cycle at level 2
    do_reset();
    cmd_valid = 1'b1; cmd_data = 8'hA1; step();
    cmd_data = 8'hB2; step();
    cmd_valid = 1'b0;
    repeat (5) step();
    chk("pp_level_before", fifo_level, 3'd2);
    cmd_valid = 1'b1; cmd_data = 8'hC3; step();
    cmd_valid = 1'b0;
    chk("pp_level_after", fifo_level, 3'd2);
    chk("pp_sent", cmd_sent, 1'b1);
    chk("pp_bx", bx_cnt, 12'd1);
    grab_chk("pp_frame1", 8'hA1);
    grab_chk("pp_frame2", 8'hB2);
    grab_chk("pp_frame3", 8'hC3);
    grab_chk("pp_frame4", IDLE);
    chk("pp_level_end", fifo_level, 3'd0);

    // Auto BCR in a short orbit delays a queued command by one frame
    sel_s = 1'b1;
    do_reset();
    s_bcr_en = 1'b1;
    repeat (50) step();
    s_cmd_valid = 1'b1; s_cmd_data = 8'h11; step();
    s_cmd_valid = 1'b0;
    repeat (5) step();
    chk("bcr_bx", s_bx_cnt, 12'd7);
    chk("bcr_sent", s_bcr_sent, 1'b1);
    chk("bcr_cmd_sent", s_cmd_sent, 1'b0);
    chk("bcr_level", s_fifo_level, 3'd1);
    grab_chk("bcr_frame", BCR);
    chk("wrap_bx", s_bx_cnt, 12'd0);
    chk("wrap_cmd_sent", s_cmd_sent, 1'b1);
    chk("wrap_bcr_sent", s_bcr_sent, 1'b0);
    chk("wrap_level", s_fifo_level, 3'd0);
    grab_chk("wrap_frame", 8'h11);
    s_bcr_en = 1'b0;
    repeat (48) step();
    chk("nobcr_bx", s_bx_cnt, 12'd7);
    chk("nobcr_sent", s_bcr_sent, 1'b0);
    grab_chk("nobcr_frame", IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
